// File: rtl/pcc_pkg.sv
// Shared types and width helpers for the popcount comparator stream.
package pcc_pkg;

    typedef enum logic {
        CMP_GE = 1'b0,
        CMP_GT = 1'b1
    } cmp_mode_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count of an N-bit vector.
module popcount_tree
    import pcc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          bits,
    output logic [cnt_w(N)-1:0]   cnt
);

    localparam int CW = cnt_w(N);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/pcc_stream.sv
// Three-stage valid/ready popcount comparator: popcnt(pos)+bias vs popcnt(neg),
// with per-side LSB drop, GE/GT mode and a saturating hit counter.
module pcc_stream
    import pcc_pkg::*;
#(
    parameter int N_POS    = 8,
    parameter int N_NEG    = 8,
    parameter int DROP_POS = 0,
    parameter int DROP_NEG = 0,
    parameter int BIAS_W   = 4,
    parameter int HIT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_POS-1:0]  in_pos,
    input  logic [N_NEG-1:0]  in_neg,
    input  logic [BIAS_W-1:0] in_bias,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_dec,
    output logic [HIT_W-1:0]  hit_cnt,
    input  logic              hit_clr
);

    localparam int MAXN  = (N_POS > N_NEG) ? N_POS : N_NEG;
    localparam int CNT_W = cnt_w(MAXN);
    localparam int CMP_W = CNT_W + BIAS_W + 1;
    localparam int PW    = cnt_w(N_POS);
    localparam int NW    = cnt_w(N_NEG);

    logic              s1_v, s2_v, s3_v;
    logic [N_POS-1:0]  s1_pos;
    logic [N_NEG-1:0]  s1_neg;
    logic [BIAS_W-1:0] s1_bias, s2_bias;
    cmp_mode_e         s1_mode, s2_mode;
    logic [CNT_W-1:0]  s2_p, s2_n;
    logic              s3_dec;

    logic s1_load, s2_load, s3_load, s3_unload;

    // Each stage may refill in the same cycle it drains.
    assign s3_unload = s3_v & out_ready;
    assign s3_load   = s2_v & (~s3_v | s3_unload);
    assign s2_load   = s1_v & (~s2_v | s3_load);
    assign in_ready  = ~s1_v | s2_load;
    assign s1_load   = in_valid & in_ready;

    logic [PW-1:0]    pc_pos;
    logic [NW-1:0]    pc_neg;
    logic [CNT_W-1:0] p_trunc, n_trunc;

    popcount_tree #(.N(N_POS)) u_pc_pos (.bits(s1_pos), .cnt(pc_pos));
    popcount_tree #(.N(N_NEG)) u_pc_neg (.bits(s1_neg), .cnt(pc_neg));

    assign p_trunc = (CNT_W'(pc_pos) >> DROP_POS) << DROP_POS;
    assign n_trunc = (CNT_W'(pc_neg) >> DROP_NEG) << DROP_NEG;

    logic signed [CMP_W-1:0] l_val, n_val;
    logic                    dec;

    // Zero-extend counts, sign-extend bias; the extra bit rules out overflow.
    assign l_val = $signed({{(BIAS_W + 1){1'b0}}, s2_p})
                 + $signed({{(CNT_W + 1){s2_bias[BIAS_W-1]}}, s2_bias});
    assign n_val = $signed({{(BIAS_W + 1){1'b0}}, s2_n});
    assign dec   = (s2_mode == CMP_GT) ? (l_val > n_val) : (l_val >= n_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_pos  <= '0;
            s1_neg  <= '0;
            s1_bias <= '0;
            s1_mode <= CMP_GE;
        end else begin
            s1_v <= s1_load | (s1_v & ~s2_load);
            if (s1_load) begin
                s1_pos  <= in_pos;
                s1_neg  <= in_neg;
                s1_bias <= in_bias;
                s1_mode <= cmp_mode_e'(in_mode);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_p    <= '0;
            s2_n    <= '0;
            s2_bias <= '0;
            s2_mode <= CMP_GE;
        end else begin
            s2_v <= s2_load | (s2_v & ~s3_load);
            if (s2_load) begin
                s2_p    <= p_trunc;
                s2_n    <= n_trunc;
                s2_bias <= s1_bias;
                s2_mode <= s1_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v   <= 1'b0;
            s3_dec <= 1'b0;
        end else begin
            s3_v <= s3_load | (s3_v & ~s3_unload);
            if (s3_load) begin
                s3_dec <= dec;
            end
        end
    end

    assign out_valid = s3_v;
    assign out_dec   = s3_dec;

    // Clear wins over a coincident hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (hit_clr) begin
            hit_cnt <= '0;
        end else if (s3_unload && s3_dec && hit_cnt != {HIT_W{1'b1}}) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pcc_stream.sv
// Scoreboard bench: default instance plus a DROP=2 / HIT_W=3 instance on the same stream.
module tb_pcc_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_mode, out_ready, hit_clr;
    logic [7:0] in_pos, in_neg;
    logic [3:0] in_bias;
    logic       in_ready, out_valid, out_dec;
    logic       in_ready2, out_valid2, out_dec2;
    logic [15:0] hit1;
    logic [2:0]  hit2;

    always #5 clk = ~clk;

    pcc_stream dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg),
        .in_bias(in_bias), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dec(out_dec), .hit_cnt(hit1), .hit_clr(hit_clr)
    );

    pcc_stream #(.DROP_POS(2), .DROP_NEG(2), .HIT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_pos(in_pos), .in_neg(in_neg),
        .in_bias(in_bias), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_dec(out_dec2), .hit_cnt(hit2), .hit_clr(hit_clr)
    );

    typedef struct {
        logic d1;
        logic d2;
        int   cyc;
        bit   lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    bit   lat_chk = 1'b1;
    int   m_hit1 = 0;
    int   m_hit2 = 0;
    logic prev_stall = 1'b0;
    logic prev_dec = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic ref_dec(input logic [7:0] p, input logic [7:0] n,
                                     input logic [3:0] b, input logic m,
                                     input int drop);
        int pc = ($countones(p) >> drop) << drop;
        int nc = ($countones(n) >> drop) << drop;
        int l  = pc + int'($signed(b));
        return m ? (l > nc) : (l >= nc);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_hit1 = 0;
            m_hit2 = 0;
            prev_stall = 1'b0;
        end else begin
            exp_t it;
            cyc++;
            chk("hit1", 32'(hit1), m_hit1);
            chk("hit2", 32'(hit2), m_hit2);
            chk("valid2", 32'(out_valid2), 32'(out_valid));
            chk("ready2", 32'(in_ready2), 32'(in_ready));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_dec", 32'(out_dec), 32'(prev_dec));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    it = q.pop_front();
                    chk("dec", 32'(out_dec), 32'(it.d1));
                    chk("dec_drop", 32'(out_dec2), 32'(it.d2));
                    if (it.lat) chk("latency", cyc - it.cyc, 3);
                    if (!hit_clr) begin
                        if (it.d1 && m_hit1 != 65535) m_hit1++;
                        if (it.d2 && m_hit2 != 7) m_hit2++;
                    end
                end
            end
            if (hit_clr) begin
                m_hit1 = 0;
                m_hit2 = 0;
            end
            prev_stall = out_valid & ~out_ready;
            prev_dec   = out_dec;
            if (in_valid && in_ready) begin
                it.d1  = ref_dec(in_pos, in_neg, in_bias, in_mode, 0);
                it.d2  = ref_dec(in_pos, in_neg, in_bias, in_mode, 2);
                it.cyc = cyc;
                it.lat = lat_chk;
                q.push_back(it);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] p, input logic [7:0] n,
                        input logic [3:0] b, input logic m);
        bit acc = 1'b0;
        int k = 0;
        in_pos   = p;
        in_neg   = n;
        in_bias  = b;
        in_mode  = m;
        in_valid = 1'b1;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int k;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pos = '0;
        in_neg = '0;
        in_bias = '0;
        in_mode = 1'b0;
        out_ready = 1'b1;
        hit_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_dec", 32'(out_dec), 0);
        chk("rst_hit", 32'(hit1), 0);

        send(8'hFF, 8'h00, 4'd0, 1'b0);
        drain();
        send(8'h0F, 8'h0F, 4'd0, 1'b0);
        send(8'h0F, 8'h0F, 4'd0, 1'b1);
        drain();

        send(8'h03, 8'h07, 4'd1, 1'b0);
        send(8'h03, 8'h07, 4'd2, 1'b0);
        send(8'hFF, 8'h00, 4'h8, 1'b0);
        drain();

        send(8'h7F, 8'h1F, 4'd0, 1'b1);
        send(8'h7F, 8'h1F, 4'd0, 1'b0);
        send(8'h07, 8'h01, 4'd0, 1'b0);
        drain();

        lat_chk = 1'b0;
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("acc_stall", acc_cnt - a0, 3);
                chk("in_ready_stall", 32'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("acc_total", acc_cnt - a0, 10);

        lat_chk = 1'b1;
        repeat (9) send(8'hFF, 8'h00, 4'd0, 1'b0);
        drain();
        chk("hit_sat", 32'(hit2), 7);

        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(8'hFF, 8'h00, 4'd0, 1'b0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk("wait_valid_timeout", 0, 1);
        @(posedge clk);
        #1;
        hit_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        hit_clr = 1'b0;
        chk("hit_clr1", 32'(hit1), 0);
        chk("hit_clr2", 32'(hit2), 0);
        lat_chk = 1'b1;

        send(8'hFF, 8'h00, 4'd0, 1'b0);
        drain();
        send(8'hFF, 8'h00, 4'd0, 1'b0);
        send(8'hFF, 8'h00, 4'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_hit1", 32'(hit1), 0);
        chk("arst_hit2", 32'(hit2), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        send(8'h01, 8'h03, 4'd1, 1'b1);
        drain();
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
